timer_counter: RTL and testbench
================================

# timer_counter

Time-value register bank for the countdown timer: four independent wrapping counters (ms, sec, min, hr) that respond to per-field up/down strobes from the timer control FSM. It returns the current value of every field and combinational carry/borrow flags. The control FSM uses these flags in the same cycle to cascade strobes into the next field. The block sits directly between the control FSM and the display/encode path.

## Interface
Parameters:
- MS_MAX, 999, ms field terminal value
- SEC_MAX, 59, sec field terminal value
- MIN_MAX, 59, min field terminal value
- HR_MAX, 23, hr field terminal value

Ports:
- i_clk  input  1  clock; one ms tick per enabled cycle
- i_rstn  input  1  asynchronous, active-low reset
- i_clr  input  1  synchronous clear of all fields
- i_ms_up / i_ms_down  input  1 each  ms increment / decrement strobe
- i_sec_up / i_sec_down  input  1 each  sec increment / decrement strobe
- i_min_up / i_min_down  input  1 each  min increment / decrement strobe
- i_hr_up / i_hr_down  input  1 each  hr increment / decrement strobe
- o_ms  output  10  ms value, 0..MS_MAX
- o_sec  output  6  sec value, 0..SEC_MAX
- o_min  output  6  min value, 0..MIN_MAX
- o_hr  output  5  hr value, 0..HR_MAX
- o_ms_carryup / o_ms_borrowdown  output  1 each  ms wrap flags
- o_sec_carryup / o_sec_borrowdown  output  1 each  sec wrap flags
- o_min_carryup / o_min_borrowdown  output  1 each  min wrap flags
- o_hr_carryup / o_hr_borrowdown  output  1 each  hr wrap flags
- o_allzero  output  1  all four fields are 0

## Operation
Each field F has MAX = F_MAX. Effective command per field:
- up = i_F_up & ~i_F_down
- down = i_F_down & ~i_F_up
- both strobes or neither: hold, no flag.

Next-value rules:
- up: F == MAX -> 0, else F+1.
- down: F == 0 -> MAX, else F-1.
- Fields are independent. The block never cascades internally. The ms borrow does not touch sec unless i_sec_down is asserted externally.

Flags, combinational from current value and strobes:
- F_carryup = up & (F == MAX)
- F_borrowdown = down & (F == 0)

Clear, reset and range:
- i_clr: all fields load 0 next edge, overriding every strobe. Flags are forced 0 while i_clr = 1.
- Out-of-range value (unreachable, defensive): next edge loads 0 regardless of strobes. Flags are 0.
- o_allzero = (o_hr, o_min, o_sec, o_ms all 0), combinational from registers.
- Reset: all fields 0, o_allzero = 1. All flags 0 while reset is held, because the strobes are gated by the control FSM's init state.

## Timing
- Value update latency: 1 cycle. A strobe in cycle n is visible on o_F at cycle n+1.
- Flags have zero latency and are valid in the same cycle as the strobe. The control FSM's path is flag -> next-field strobe -> register. This whole path must close in one cycle, with no registered flags.
- Cascade example: all four down strobes, each gated by the lower borrow, update every field on the same edge.
- Asynchronous reset mid-operation clears all fields immediately. The first edge after deassertion obeys the normal rules.
- No combinational path exists from any output back to itself. Flags depend only on the registers and the strobes of that field.

## Test plan
- Reset: hold i_rstn = 0 with random strobes -> all fields 0 and o_allzero = 1. After release, one i_ms_up -> o_ms = 1 next cycle.
- ms underflow: o_ms = 0 with i_ms_down -> o_ms_borrowdown = 1 same cycle, o_ms = 999 next cycle, other fields unchanged.
- Full cascade: load 1:00:00.000 via up strobes. Bench drives i_sec_down = o_ms_borrowdown, i_min_down = o_sec_borrowdown, i_hr_down = o_min_borrowdown, plus i_ms_down -> next cycle 0:59:59.999, o_allzero = 0.
- Wrap up: sec = 59 with i_sec_up -> o_sec_carryup = 1, then sec = 0. hr = 23 with i_hr_up -> hr = 0. hr = 0 with i_hr_down -> hr = 23, o_hr_borrowdown = 1.
- Conflicts: i_min_up & i_min_down at min = 0 -> min stays 0, no flags. i_clr together with i_ms_down at ms = 0 -> ms = 0, borrow = 0.
- Reset mid-count: pulse i_rstn low asynchronously between edges at 0:12:34.567 -> outputs 0 before the next edge, counting resumes from 0.

Source files
------------

// File: rtl/timer_counter.sv
// Time-value register bank: four independent wrapping counters
// (ms, sec, min, hr) with same-cycle carry/borrow flags.

module timer_counter_field #(
  parameter int W   = 10,
  parameter int MAX = 999
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         up_req,
  input  logic         down_req,
  output logic [W-1:0] value,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic         up;
  logic         down;
  logic         in_range;
  logic [W-1:0] nxt;

  assign up       = up_req & ~down_req;
  assign down     = down_req & ~up_req;
  assign in_range = (value <= MAX_V);

  // Flags stay low during reset/clear so the FSM cascade never fires then.
  assign carry  = rstn & ~clr & up & (value == MAX_V);
  assign borrow = rstn & ~clr & down & (value == '0);

  always_comb begin
    nxt = value;
    if (clr || !in_range) begin
      nxt = '0;
    end else if (up) begin
      nxt = (value == MAX_V) ? '0 : value + 1'b1;
    end else if (down) begin
      nxt = (value == '0) ? MAX_V : value - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else begin
      value <= nxt;
    end
  end

endmodule

module timer_counter #(
  parameter int MS_MAX  = 999,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clr,
  input  logic       i_ms_up,
  input  logic       i_ms_down,
  input  logic       i_sec_up,
  input  logic       i_sec_down,
  input  logic       i_min_up,
  input  logic       i_min_down,
  input  logic       i_hr_up,
  input  logic       i_hr_down,
  output logic [9:0] o_ms,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic       o_ms_carryup,
  output logic       o_ms_borrowdown,
  output logic       o_sec_carryup,
  output logic       o_sec_borrowdown,
  output logic       o_min_carryup,
  output logic       o_min_borrowdown,
  output logic       o_hr_carryup,
  output logic       o_hr_borrowdown,
  output logic       o_allzero
);

  timer_counter_field #(.W(10), .MAX(MS_MAX)) u_ms (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .clr      (i_clr),
    .up_req   (i_ms_up),
    .down_req (i_ms_down),
    .value    (o_ms),
    .carry    (o_ms_carryup),
    .borrow   (o_ms_borrowdown)
  );

  timer_counter_field #(.W(6), .MAX(SEC_MAX)) u_sec (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .clr      (i_clr),
    .up_req   (i_sec_up),
    .down_req (i_sec_down),
    .value    (o_sec),
    .carry    (o_sec_carryup),
    .borrow   (o_sec_borrowdown)
  );

  timer_counter_field #(.W(6), .MAX(MIN_MAX)) u_min (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .clr      (i_clr),
    .up_req   (i_min_up),
    .down_req (i_min_down),
    .value    (o_min),
    .carry    (o_min_carryup),
    .borrow   (o_min_borrowdown)
  );

  timer_counter_field #(.W(5), .MAX(HR_MAX)) u_hr (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .clr      (i_clr),
    .up_req   (i_hr_up),
    .down_req (i_hr_down),
    .value    (o_hr),
    .carry    (o_hr_carryup),
    .borrow   (o_hr_borrowdown)
  );

  assign o_allzero = (o_hr == '0) && (o_min == '0) &&
                     (o_sec == '0) && (o_ms == '0);

endmodule

// File: tb/tb_timer_counter.sv
// Randomized bench for timer_counter against a modular-arithmetic
// time model.

module tb_timer_counter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic       ms_up = 0, ms_dn = 0, sec_up = 0, sec_dn = 0;
  logic       min_up = 0, min_dn = 0, hr_up = 0, hr_dn = 0;
  logic [9:0] ms;
  logic [5:0] sec, mn;
  logic [4:0] hr;
  logic       ms_c, ms_b, sec_c, sec_b, min_c, min_b, hr_c, hr_b;
  logic       allzero;

  int checks = 0;
  int errors = 0;
  int m_ms = 0, m_sec = 0, m_min = 0, m_hr = 0;

  timer_counter dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_clr            (clr),
    .i_ms_up          (ms_up),
    .i_ms_down        (ms_dn),
    .i_sec_up         (sec_up),
    .i_sec_down       (sec_dn),
    .i_min_up         (min_up),
    .i_min_down       (min_dn),
    .i_hr_up          (hr_up),
    .i_hr_down        (hr_dn),
    .o_ms             (ms),
    .o_sec            (sec),
    .o_min            (mn),
    .o_hr             (hr),
    .o_ms_carryup     (ms_c),
    .o_ms_borrowdown  (ms_b),
    .o_sec_carryup    (sec_c),
    .o_sec_borrowdown (sec_b),
    .o_min_carryup    (min_c),
    .o_min_borrowdown (min_b),
    .o_hr_carryup     (hr_c),
    .o_hr_borrowdown  (hr_b),
    .o_allzero        (allzero)
  );

  always #5 clk = ~clk;

  // Time arithmetic: a field is a residue modulo (max+1).
  function automatic int fnext(int v, int mx, logic u, logic d);
    if (u && !d) return (v + 1) % (mx + 1);
    if (d && !u) return (v + mx) % (mx + 1);
    return v;
  endfunction

  function automatic logic [7:0] model_flags();
    logic [7:0] f;
    f[7] = !clr && ms_up && !ms_dn && m_ms == 999;
    f[6] = !clr && ms_dn && !ms_up && m_ms == 0;
    f[5] = !clr && sec_up && !sec_dn && m_sec == 59;
    f[4] = !clr && sec_dn && !sec_up && m_sec == 0;
    f[3] = !clr && min_up && !min_dn && m_min == 59;
    f[2] = !clr && min_dn && !min_up && m_min == 0;
    f[1] = !clr && hr_up && !hr_dn && m_hr == 23;
    f[0] = !clr && hr_dn && !hr_up && m_hr == 0;
    return f;
  endfunction

  function automatic logic [7:0] dut_flags();
    return {ms_c, ms_b, sec_c, sec_b, min_c, min_b, hr_c, hr_b};
  endfunction

  function automatic logic [26:0] model_vals();
    return {m_hr[4:0], m_min[5:0], m_sec[5:0], m_ms[9:0]};
  endfunction

  function automatic logic [26:0] dut_vals();
    return {hr, mn, sec, ms};
  endfunction

  task automatic idle();
    clr = 0;
    ms_up = 0; ms_dn = 0; sec_up = 0; sec_dn = 0;
    min_up = 0; min_dn = 0; hr_up = 0; hr_dn = 0;
  endtask

  // Advance one edge, moving the model with the strobes seen before it.
  task automatic tick();
    logic c;
    logic [7:0] s;
    c = clr;
    s = {ms_up, ms_dn, sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn};
    @(posedge clk);
    if (rstn) begin
      if (c) begin
        m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
      end else begin
        m_ms  = fnext(m_ms, 999, s[7], s[6]);
        m_sec = fnext(m_sec, 59, s[5], s[4]);
        m_min = fnext(m_min, 59, s[3], s[2]);
        m_hr  = fnext(m_hr, 23, s[1], s[0]);
      end
    end
    #1;
    idle();
  endtask

  task automatic test_reset();
    rstn = 0;
    for (int i = 0; i < 6; i++) begin
      {ms_up, ms_dn, sec_up, sec_dn} = 4'($urandom);
      {min_up, min_dn, hr_up, hr_dn} = 4'($urandom);
      #1;
      checks++;
      if (dut_vals() !== 27'd0 || allzero !== 1'b1 || dut_flags() !== 8'd0) begin
        errors++;
        $display("FAIL reset: vals=%h allzero=%b flags=%b, want 0/1/0",
                 dut_vals(), allzero, dut_flags());
      end
      tick();
    end
    rstn = 1;
    m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
    ms_up = 1;
    tick();
    checks++;
    if (ms !== 10'd1) begin
      errors++;
      $display("FAIL reset_first_up: ms=%0d want 1", ms);
    end
  endtask

  task automatic test_ms_underflow();
    clr = 1;
    tick();
    sec_up = 1; min_up = 1; hr_up = 1;
    tick();
    ms_dn = 1;
    #1;
    checks++;
    if (ms_b !== 1'b1 || ms_c !== 1'b0) begin
      errors++;
      $display("FAIL ms_borrow: b=%b c=%b want 1/0", ms_b, ms_c);
    end
    tick();
    checks++;
    if (ms !== 10'd999 || sec !== 6'd1 || mn !== 6'd1 || hr !== 5'd1) begin
      errors++;
      $display("FAIL ms_underflow: %0d:%0d:%0d.%0d want 1:1:1.999",
               hr, mn, sec, ms);
    end
  endtask

  task automatic test_cascade();
    clr = 1;
    tick();
    hr_up = 1;
    tick();
    ms_dn = 1;
    #1 sec_dn = ms_b;
    #1 min_dn = sec_b;
    #1 hr_dn = min_b;
    #1;
    checks++;
    if ({ms_b, sec_b, min_b, hr_b} !== 4'b1110) begin
      errors++;
      $display("FAIL cascade_flags: %b want 1110",
               {ms_b, sec_b, min_b, hr_b});
    end
    tick();
    checks++;
    if (dut_vals() !== model_vals() || hr !== 5'd0 || mn !== 6'd59 ||
        sec !== 6'd59 || ms !== 10'd999 || allzero !== 1'b0) begin
      errors++;
      $display("FAIL cascade: %0d:%0d:%0d.%0d az=%b want 0:59:59.999 az=0",
               hr, mn, sec, ms, allzero);
    end
  endtask

  task automatic test_wrap();
    clr = 1;
    tick();
    for (int i = 0; i < 59; i++) begin
      sec_up = 1;
      hr_up = (i < 23);
      tick();
    end
    sec_up = 1;
    hr_up = 1;
    #1;
    checks++;
    if (sec_c !== 1'b1 || hr_c !== 1'b1) begin
      errors++;
      $display("FAIL wrap_carry: sec_c=%b hr_c=%b want 1/1", sec_c, hr_c);
    end
    tick();
    checks++;
    if (sec !== 6'd0 || hr !== 5'd0) begin
      errors++;
      $display("FAIL wrap_up: sec=%0d hr=%0d want 0/0", sec, hr);
    end
    hr_dn = 1;
    #1;
    checks++;
    if (hr_b !== 1'b1) begin
      errors++;
      $display("FAIL hr_borrow: %b want 1", hr_b);
    end
    tick();
    checks++;
    if (hr !== 5'd23) begin
      errors++;
      $display("FAIL hr_underflow: hr=%0d want 23", hr);
    end
  endtask

  task automatic test_conflicts();
    clr = 1;
    tick();
    min_up = 1; min_dn = 1;
    #1;
    checks++;
    if (min_c !== 1'b0 || min_b !== 1'b0) begin
      errors++;
      $display("FAIL conflict_flags: c=%b b=%b want 0/0", min_c, min_b);
    end
    tick();
    checks++;
    if (mn !== 6'd0) begin
      errors++;
      $display("FAIL conflict_hold: min=%0d want 0", mn);
    end
    clr = 1; ms_dn = 1;
    #1;
    checks++;
    if (ms_b !== 1'b0) begin
      errors++;
      $display("FAIL clr_flag: borrow=%b want 0", ms_b);
    end
    tick();
    checks++;
    if (ms !== 10'd0 || allzero !== 1'b1) begin
      errors++;
      $display("FAIL clr_value: ms=%0d az=%b want 0/1", ms, allzero);
    end
  endtask

  task automatic test_reset_mid();
    clr = 1;
    tick();
    for (int i = 0; i < 567; i++) begin
      ms_up = 1;
      sec_up = (i < 34);
      min_up = (i < 12);
      tick();
    end
    checks++;
    if (dut_vals() !== model_vals() || hr !== 5'd0 || mn !== 6'd12 ||
        sec !== 6'd34 || ms !== 10'd567) begin
      errors++;
      $display("FAIL preload: %0d:%0d:%0d.%0d want 0:12:34.567",
               hr, mn, sec, ms);
    end
    #2 rstn = 0;
    #1;
    checks++;
    if (dut_vals() !== 27'd0 || allzero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: vals=%h az=%b want 0/1",
               dut_vals(), allzero);
    end
    #1 rstn = 1;
    m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
    ms_up = 1;
    tick();
    checks++;
    if (dut_vals() !== 27'd1) begin
      errors++;
      $display("FAIL resume: vals=%h want 1", dut_vals());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      {ms_up, ms_dn, sec_up, sec_dn} = 4'($urandom);
      {min_up, min_dn, hr_up, hr_dn} = 4'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (dut_flags() !== model_flags()) begin
        errors++;
        $display("FAIL rand_flags[%0d]: %b want %b",
                 i, dut_flags(), model_flags());
      end
      tick();
      checks++;
      if (dut_vals() !== model_vals() ||
          allzero !== (model_vals() == 27'd0)) begin
        errors++;
        $display("FAIL rand_vals[%0d]: %h az=%b want %h",
                 i, dut_vals(), allzero, model_vals());
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_ms_underflow();
    test_cascade();
    test_wrap();
    test_conflicts();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
